instruction_fetch: RTL and testbench

IF stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one word fetch at a time to instruction memory over a req/ready, rvalid handshake.
- Presents pc/instruction pairs to IF/ID with a write strobe.
- Honours the hazard-unit stall and the EX-stage branch redirect, flushing IF/ID on redirect.

---
 rtl/instruction_fetch_pkg.sv | 16 +
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch_pc_register.sv | 26 ++
 rtl/instruction_fetch.sv | 153 +++++++++++++++
 tb/tb_instruction_fetch.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DISCARD
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bus: one word read per accepted request.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/instruction_fetch_pc_register.sv
// Program counter: async reset to RESET_PC, redirect load beats sequential increment.
module instruction_fetch_pc_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_value,
    input  logic            inc,
    output logic [XLEN-1:0] pc
);

    // PC update; increment wraps naturally modulo 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + PC_INC;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues single outstanding word fetches and feeds IF/ID.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [XLEN-1:0]      branch_target,
    instruction_fetch_if.master  imem,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic [XLEN-1:0]      pc_out,
    output logic [XLEN-1:0]      instruction_out
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] buffer;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] last_instr;
    logic            pc_load;
    logic            pc_inc;
    logic            capture_fetch;
    logic            capture_buffer;
    logic            req_c;
    logic            write_c;
    logic [XLEN-1:0] present_pc;
    logic [XLEN-1:0] present_instr;
    logic            unused_target_bits;

    // Redirect targets are always word aligned; the low bits are dropped
    assign redirect_pc        = {branch_target[XLEN-1:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    instruction_fetch_pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .load_value (redirect_pc),
        .inc        (pc_inc),
        .pc         (pc)
    );

    // Fetch state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; redirect outranks stall and returning data
    always_comb begin
        state_next     = state;
        pc_load        = 1'b0;
        pc_inc         = 1'b0;
        capture_fetch  = 1'b0;
        capture_buffer = 1'b0;
        req_c          = 1'b0;
        write_c        = 1'b0;
        present_pc     = last_pc;
        present_instr  = last_instr;
        case (state)
            ST_REQ: begin
                req_c = !branch_taken;
                if (branch_taken) begin
                    pc_load = 1'b1;
                end else if (imem.ready) begin
                    capture_fetch = 1'b1;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (branch_taken) begin
                    pc_load    = 1'b1;
                    state_next = imem.rvalid ? ST_REQ : ST_DISCARD;
                end else if (imem.rvalid) begin
                    if (!stall) begin
                        write_c       = 1'b1;
                        present_pc    = fetch_pc;
                        present_instr = imem.rdata;
                        pc_inc        = 1'b1;
                        state_next    = ST_REQ;
                    end else begin
                        capture_buffer = 1'b1;
                        state_next     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                present_pc    = fetch_pc;
                present_instr = buffer;
                if (branch_taken) begin
                    pc_load    = 1'b1;
                    state_next = ST_REQ;
                end else if (!stall) begin
                    write_c    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                end
                if (imem.rvalid) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    // Fetch address, held stall data and last values presented to IF/ID
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc   <= '0;
            buffer     <= '0;
            last_pc    <= '0;
            last_instr <= '0;
        end else begin
            if (capture_fetch) begin
                fetch_pc <= pc;
            end
            if (capture_buffer) begin
                buffer <= imem.rdata;
            end
            if (write_c) begin
                last_pc    <= present_pc;
                last_instr <= present_instr;
            end
        end
    end

    assign imem.req        = reset & req_c;
    assign imem.addr       = pc;
    assign if_id_flush     = reset & branch_taken;
    assign if_id_write     = write_c;
    assign pc_out          = present_pc;
    assign instruction_out = present_instr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed cycle-by-cycle bench for the instruction fetch stage.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_write;
    logic        if_id_flush;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;

    int unsigned n_tests;
    int unsigned n_fail;

    instruction_fetch_if imem ();

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem            (imem),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .pc_out          (pc_out),
        .instruction_out (instruction_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_write;
        logic        exp_flush;
        logic        chk_data;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input logic req, input logic [31:0] addr,
                                 input logic wr, input logic fl, input logic chk,
                                 input logic [31:0] pc_e, input logic [31:0] ins_e);
        check({tag, " imem_req"},    32'(imem.req),    32'(req));
        check({tag, " imem_addr"},   imem.addr,        addr);
        check({tag, " if_id_write"}, 32'(if_id_write), 32'(wr));
        check({tag, " if_id_flush"}, 32'(if_id_flush), 32'(fl));
        if (chk) begin
            check({tag, " pc_out"},          pc_out,          pc_e);
            check({tag, " instruction_out"}, instruction_out, ins_e);
        end
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        imem.ready    = rdy;
        imem.rvalid   = rv;
        imem.rdata    = rd;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // stall, br, tgt, ready, rvalid, rdata | req, addr, write, flush, chk, pc_out, instr_out
        // Basic fetch: accept at 0x0, bypass write, next address 0x4
        vecs.push_back('{0,0,32'h0,        1,0,32'h0,        1,32'h0,        0,0, 1,32'h0,        32'h0});
        vecs.push_back('{0,0,32'h0,        0,1,32'h00500093, 0,32'h0,        1,0, 1,32'h0,        32'h00500093});
        vecs.push_back('{0,0,32'h0,        1,0,32'h0,        1,32'h4,        0,0, 1,32'h0,        32'h00500093});
        // Data arrives under a 3-cycle stall, released to IF/ID afterwards
        vecs.push_back('{1,0,32'h0,        0,1,32'h00A00113, 0,32'h4,        0,0, 1,32'h0,        32'h00500093});
        vecs.push_back('{1,0,32'h0,        0,0,32'h0,        0,32'h4,        0,0, 1,32'h4,        32'h00A00113});
        vecs.push_back('{1,0,32'h0,        0,0,32'h0,        0,32'h4,        0,0, 1,32'h4,        32'h00A00113});
        vecs.push_back('{0,0,32'h0,        0,0,32'h0,        0,32'h4,        1,0, 1,32'h4,        32'h00A00113});
        // Memory not ready for 5 cycles: request and address stable
        for (int i = 0; i < 5; i++)
            vecs.push_back('{0,0,32'h0,    0,0,32'h0,        1,32'h8,        0,0, 1,32'h4,        32'h00A00113});
        vecs.push_back('{0,0,32'h0,        1,0,32'h0,        1,32'h8,        0,0, 1,32'h4,        32'h00A00113});
        // Redirect while waiting, late response dropped
        vecs.push_back('{0,1,32'h103,      0,0,32'h0,        0,32'h8,        0,1, 1,32'h4,        32'h00A00113});
        vecs.push_back('{0,0,32'h0,        0,0,32'h0,        0,32'h100,      0,0, 1,32'h4,        32'h00A00113});
        vecs.push_back('{0,0,32'h0,        0,1,32'hDEADBEEF, 0,32'h100,      0,0, 1,32'h4,        32'h00A00113});
        vecs.push_back('{0,0,32'h0,        1,0,32'h0,        1,32'h100,      0,0, 1,32'h4,        32'h00A00113});
        // Redirect, stall and rvalid together: redirect wins, no write
        vecs.push_back('{1,1,32'h200,      0,1,32'h11111111, 0,32'h100,      0,1, 1,32'h4,        32'h00A00113});
        vecs.push_back('{0,0,32'h0,        0,0,32'h0,        1,32'h200,      0,0, 1,32'h4,        32'h00A00113});
        // Redirect in REQ suppresses the request
        vecs.push_back('{0,1,32'h300,      1,0,32'h0,        0,32'h200,      0,1, 1,32'h4,        32'h00A00113});
        // Spurious rvalid in REQ ignored
        vecs.push_back('{0,0,32'h0,        1,1,32'h44444444, 1,32'h300,      0,0, 1,32'h4,        32'h00A00113});
        vecs.push_back('{0,0,32'h0,        0,1,32'h00000013, 0,32'h300,      1,0, 1,32'h300,      32'h00000013});
        // Redirect out of HOLD drops the buffered word
        vecs.push_back('{0,0,32'h0,        1,0,32'h0,        1,32'h304,      0,0, 1,32'h300,      32'h00000013});
        vecs.push_back('{1,0,32'h0,        0,1,32'h22222222, 0,32'h304,      0,0, 1,32'h300,      32'h00000013});
        vecs.push_back('{0,1,32'h400,      0,0,32'h0,        0,32'h304,      0,1, 1,32'h304,      32'h22222222});
        // Redirect to top word with unaligned target, then PC wraps to 0
        vecs.push_back('{0,1,32'hFFFFFFFF, 0,0,32'h0,        0,32'h400,      0,1, 1,32'h300,      32'h00000013});
        vecs.push_back('{0,0,32'h0,        1,0,32'h0,        1,32'hFFFFFFFC, 0,0, 1,32'h300,      32'h00000013});
        vecs.push_back('{0,0,32'h0,        0,1,32'h00000033, 0,32'hFFFFFFFC, 1,0, 1,32'hFFFFFFFC, 32'h00000033});
        vecs.push_back('{0,0,32'h0,        1,0,32'h0,        1,32'h0,        0,0, 1,32'hFFFFFFFC, 32'h00000033});

        // Reset state
        #2;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].ready, vecs[i].rvalid, vecs[i].rdata);
            #2;
            check_outputs($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_write,
                          vecs[i].exp_flush, vecs[i].chk_data, vecs[i].exp_pc, vecs[i].exp_instr);
        end

        // Asynchronous reset while a fetch is outstanding
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 32'h55555555);
        #1;
        reset = 1'b0;
        #1;
        check_outputs("rst_async", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        #2;
        check_outputs("rst_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

        // Restart from RESET_PC after release
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #2;
        check_outputs("post_rst_req", 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00000066);
        #2;
        check_outputs("post_rst_rd", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h00000066);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        check_outputs("post_rst_next", 1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 32'h0, 32'h00000066);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
